// File: rtl/apo_injector_pkg.sv
// Shared packet field widths and injection FSM state encoding for the NI injection stage.
package apo_injector_pkg;

  localparam int INJ_K       = 8;
  localparam int INJ_N2      = 2 * INJ_K + 1;
  localparam int INJ_VLD_BIT = INJ_N2 - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SPACE
  } inj_state_t;

endpackage

// File: rtl/apo_inj_fifo.sv
// Synchronous FIFO of destination numbers; head is combinational from the read pointer.
// Push when full and pop when empty are ignored; sync active-low reset empties it.
module apo_inj_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apo_injector.sv
// NoC injection stage: queues IP requests and injects one packet into the router's local port
// only on cycles free of transit traffic; first inject one cycle after accept, req_ready = !full.
module apo_injector
  import apo_injector_pkg::*;
#(
  parameter int K          = INJ_K,
  parameter int N2         = INJ_N2,
  parameter int NODE_COUNT = 169,
  parameter int DEPTH      = 4,
  parameter int GAP        = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K-1:0]  router_name,
  input  logic          req_valid,
  input  logic [K-1:0]  req_dest,
  output logic          req_ready,
  output logic          req_err,
  input  logic [3:0]    transit_valid,
  output logic [N2-1:0] inj_pkt,
  input  logic          delivered,
  output logic [15:0]   sent_cnt,
  output logic [15:0]   recv_cnt,
  output logic [15:0]   stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE_ENTRY = (AW+1)'(1);

  inj_state_t  state;
  logic [7:0]  gap_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic [K-1:0] head;
  logic [AW:0] fifo_cnt;
  logic        accept;
  logic        legal;
  logic        push;
  logic        fire;
  logic        more;
  logic        unused_name;

  // Local delivery is handled inside the router; the node number needs no gating here.
  assign unused_name = ^router_name;

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign legal     = {{(32-K){1'b0}}, req_dest} < 32'(NODE_COUNT);
  assign push      = accept && legal;
  assign fire      = (state == ST_ARMED) && (transit_valid == 4'b0000);
  assign more      = (fifo_cnt > ONE_ENTRY) || push;

  // The router favours the local port, so injection must never overlap a transit arrival.
  assign inj_pkt = fire ? {1'b1, {(N2-K-1){1'b0}}, head} : '0;

  apo_inj_fifo #(
    .DEPTH (DEPTH),
    .W     (K)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (req_dest),
    .pop   (fire),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      req_err   <= 1'b0;
      sent_cnt  <= '0;
      recv_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      req_err <= accept && !legal;
      if (delivered) recv_cnt <= recv_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (fire) begin
            sent_cnt <= sent_cnt + 1'b1;
            if (GAP > 0) begin
              state   <= ST_SPACE;
              gap_cnt <= 8'(GAP - 1);
            end else if (!more) begin
              state <= ST_IDLE;
            end
          end else if (stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ST_SPACE: begin
          if (gap_cnt == '0) state <= fifo_empty ? ST_IDLE : ST_ARMED;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apo_injector.sv
// Directed bench for apo_injector with hand-computed expectations.
module tb_apo_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  router_name;
  logic        req_valid;
  logic [7:0]  req_dest;
  logic        req_ready;
  logic        req_err;
  logic [3:0]  transit_valid;
  logic [16:0] inj_pkt;
  logic        delivered;
  logic [15:0] sent_cnt;
  logic [15:0] recv_cnt;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  apo_injector #(
    .K(8), .N2(17), .NODE_COUNT(169), .DEPTH(4), .GAP(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .router_name   (router_name),
    .req_valid     (req_valid),
    .req_dest      (req_dest),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .transit_valid (transit_valid),
    .inj_pkt       (inj_pkt),
    .delivered     (delivered),
    .sent_cnt      (sent_cnt),
    .recv_cnt      (recv_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fire_cyc [4];
    logic [7:0] fire_dst [4];
    int nfire;
    logic stale;

    rst_n = 1'b0; router_name = 8'd42; req_valid = 1'b0; req_dest = '0;
    transit_valid = '0; delivered = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_inj", 32'(inj_pkt), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_err", 32'(req_err), 32'h0);
    chk("rst_sent", 32'(sent_cnt), 32'h0);
    chk("rst_recv", 32'(recv_cnt), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);

    // Single request, idle links.
    req_valid = 1'b1; req_dest = 8'd5;
    step();
    req_valid = 1'b0;
    #1 chk("t1_inj_early", 32'(inj_pkt), 32'h0);
    step();
    chk("t1_inj", 32'(inj_pkt), 32'h10005);
    step();
    chk("t1_inj_once", 32'(inj_pkt), 32'h0);
    chk("t1_sent", 32'(sent_cnt), 32'd1);
    step();

    // Blocked by transit traffic for three cycles.
    req_valid = 1'b1; req_dest = 8'd20; transit_valid = 4'b0010;
    step();
    req_valid = 1'b0;
    step();
    chk("t2_blk0", 32'(inj_pkt), 32'h0);
    step();
    chk("t2_blk1", 32'(inj_pkt), 32'h0);
    step(); step();
    chk("t2_blk3", 32'(inj_pkt), 32'h0);
    transit_valid = 4'b0000;
    #1;
    chk("t2_inj", 32'(inj_pkt), 32'h10014);
    chk("t2_stall", 32'(stall_cnt), 32'd3);
    step();
    chk("t2_sent", 32'(sent_cnt), 32'd2);
    step(); step();

    // Fill the FIFO under traffic, then drain at one packet per two cycles.
    transit_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_dest = 8'(i);
      #1 chk($sformatf("t3_ready%0d", i), 32'(req_ready), (i < 4) ? 32'h1 : 32'h0);
      step();
    end
    req_valid = 1'b0;
    transit_valid = 4'b0000;
    #1;
    nfire = 0;
    for (int c = 0; c < 12; c++) begin
      if (inj_pkt[16] && nfire < 4) begin
        fire_cyc[nfire] = c;
        fire_dst[nfire] = inj_pkt[7:0];
        nfire++;
      end
      step();
    end
    chk("t3_nfire", 32'(nfire), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nfire) begin
        chk($sformatf("t3_dst%0d", i), 32'(fire_dst[i]), 32'(i));
        chk($sformatf("t3_cyc%0d", i), 32'(fire_cyc[i]), 32'(2 * i));
      end
    end
    chk("t3_sent", 32'(sent_cnt), 32'd6);
    chk("t3_empty_ready", 32'(req_ready), 32'h1);

    // Illegal destination.
    req_valid = 1'b1; req_dest = 8'd169;
    step();
    req_valid = 1'b0;
    #1 chk("t4_err", 32'(req_err), 32'h1);
    chk("t4_inj", 32'(inj_pkt), 32'h0);
    step();
    chk("t4_err_once", 32'(req_err), 32'h0);
    chk("t4_inj2", 32'(inj_pkt), 32'h0);
    chk("t4_sent", 32'(sent_cnt), 32'd6);

    // Reset while three entries are queued.
    transit_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_dest = 8'(7 + i);
      step();
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_inj", 32'(inj_pkt), 32'h0);
    chk("t5_ready", 32'(req_ready), 32'h1);
    chk("t5_sent", 32'(sent_cnt), 32'h0);
    chk("t5_stall", 32'(stall_cnt), 32'h0);
    transit_valid = 4'b0000;
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 if (inj_pkt != '0) stale = 1'b1;
      step();
    end
    chk("t5_no_stale", 32'(stale), 32'h0);
    chk("t5_sent_after", 32'(sent_cnt), 32'h0);

    // Delivery counting.
    delivered = 1'b1;
    step(); step();
    delivered = 1'b0;
    step();
    chk("t6_recv", 32'(recv_cnt), 32'd2);

    // Destination equal to this node is injected normally.
    req_valid = 1'b1; req_dest = router_name;
    step();
    req_valid = 1'b0;
    step();
    chk("t7_self", 32'(inj_pkt), 32'h1002A);
    step();
    chk("t7_sent", 32'(sent_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
